// File: rtl/cache_ctrl_pkg.sv
// Shared types and widths for the direct-mapped cache controller.
// The optional statistics counters are enabled with CACHE_CTRL_STATS_EN.
package cache_ctrl_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned INDEX_W = 2;
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W;
  localparam int unsigned LINE_W  = DATA_W + TAG_W + 2;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  // Builds a valid line; dirty distinguishes CPU writes from memory fills.
  function automatic line_t make_line(input logic dirty, input logic [TAG_W-1:0] tag,
                                      input logic [DATA_W-1:0] data);
    line_t l;
    l.valid = 1'b1;
    l.dirty = dirty;
    l.tag   = tag;
    l.data  = data;
    return l;
  endfunction

endpackage

// File: rtl/cache_ctrl_stats.sv
// Saturating hit / miss / write-back counters for the cache controller.
module cache_ctrl_stats
  import cache_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             i_rst,
  input  logic             hit_inc,
  input  logic             miss_inc,
  input  logic             wb_inc,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  // Each counter sticks at all-ones instead of wrapping.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (hit_inc && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + CNT_W'(1);
    if (miss_inc && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    if (wb_inc && (wb_cnt_q != '1))     wb_cnt_d   = wb_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;

endmodule

// File: rtl/cache_ctrl.sv
// Write-back / write-allocate sequencer for a 4-line direct-mapped cache array.
// Define CACHE_CTRL_STATS_EN to add the hit_cnt / miss_cnt / wb_cnt outputs.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              i_rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [INDEX_W-1:0] cache_address,
  output logic              cache_rden,
  output logic              cache_wren,
  output logic [LINE_W-1:0] cache_data,
  input  logic [LINE_W-1:0] cache_q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
`endif
);

  state_e              state_q, state_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  line_t               victim_q, victim_d;
  logic                cpu_busy_q, cpu_busy_d;
  logic                cpu_done_q, cpu_done_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  line_t               q_line;
  line_t               wr_line;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit_c;

  assign q_line  = cache_q;
  assign req_idx = req_addr_q[INDEX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];
  assign hit_c   = q_line.valid && (q_line.tag == req_tag);

  // Next state, array strobes and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    req_we_d      = req_we_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    victim_d      = victim_q;
    cpu_done_d    = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    cache_address = '0;
    cache_rden    = 1'b0;
    cache_wren    = 1'b0;
    wr_line       = '0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        cache_address = req_idx;
        // The array read is combinational, so a write hit can drop rden in the same cycle.
        if (hit_c) begin
          cpu_done_d = 1'b1;
          state_d    = IDLE;
          if (req_we_q) begin
            cache_wren = 1'b1;
            wr_line    = make_line(1'b1, req_tag, req_wdata_q);
          end else begin
            cache_rden  = 1'b1;
            cpu_rdata_d = q_line.data;
          end
        end else begin
          cache_rden = 1'b1;
          victim_d   = q_line;
          state_d    = (q_line.valid && q_line.dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ack) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (mem_ack) begin
          cache_address = req_idx;
          cache_wren    = 1'b1;
          wr_line       = make_line(1'b0, req_tag, mem_rdata);
          state_d       = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase

    cache_data = wr_line;

    cpu_busy_d  = (state_d != IDLE);
    mem_req_d   = (state_d == WRITEBACK) || (state_d == ALLOCATE);
    mem_we_d    = (state_d == WRITEBACK);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == WRITEBACK) begin
      mem_addr_d  = {victim_d.tag, req_idx};
      mem_wdata_d = victim_d.data;
    end else if (state_d == ALLOCATE) begin
      mem_addr_d  = req_addr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      cpu_busy_q  <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      victim_q    <= victim_d;
      cpu_busy_q  <= cpu_busy_d;
      cpu_done_q  <= cpu_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_busy  = cpu_busy_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_CTRL_STATS_EN
  // refill marks the re-compare after a fill so a request is counted only once.
  logic refill_q, refill_d;
  logic first_cmp, hit_inc, miss_inc, wb_inc;

  always_comb begin
    refill_d = refill_q;
    if (state_q == IDLE)                      refill_d = 1'b0;
    else if ((state_q == ALLOCATE) && mem_ack) refill_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (i_rst) refill_q <= 1'b0;
    else       refill_q <= refill_d;
  end

  assign first_cmp = (state_q == COMPARE) && !refill_q;
  assign hit_inc   = first_cmp && hit_c;
  assign miss_inc  = first_cmp && !hit_c;
  assign wb_inc    = first_cmp && !hit_c && q_line.valid && q_line.dirty;

  cache_ctrl_stats u_stats (
    .clock    (clock),
    .i_rst    (i_rst),
    .hit_inc  (hit_inc),
    .miss_inc (miss_inc),
    .wb_inc   (wb_inc),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench: cache_ctrl paired with a 4-line array model and a word memory model.
module tb_cache_ctrl;

  logic        clock = 1'b0;
  logic        i_rst;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy, cpu_done;
  logic [31:0] cpu_rdata;
  logic [1:0]  cache_address;
  logic        cache_rden, cache_wren;
  logic [35:0] cache_data, cache_q;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cache_ctrl dut (
    .clock(clock), .i_rst(i_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cache_address(cache_address), .cache_rden(cache_rden), .cache_wren(cache_wren),
    .cache_data(cache_data), .cache_q(cache_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  // Cache array: combinational read, write on rising edge, cleared by its active-low reset.
  logic [35:0] arr [4];
  logic        arr_rst_n;
  assign arr_rst_n = ~i_rst;
  assign cache_q   = arr[cache_address];
  always @(posedge clock) begin
    if (!arr_rst_n) begin
      for (int i = 0; i < 4; i++) arr[i] <= '0;
    end else if (cache_wren) begin
      arr[cache_address] <= cache_data;
    end
  end

  // Backing memory: ack when a transfer has waited ack_delay cycles; logs every completed transfer.
  logic [31:0] mem [16];
  int          ack_delay = 3;
  int          wait_cnt = 0;
  int          xf_n = 0;
  logic        xf_we   [64];
  logic [3:0]  xf_addr [64];
  logic [31:0] xf_data [64];
  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= {16'hA5A5, 16'(i)};
      wait_cnt <= 0;
    end else begin
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
      if (mem_ack) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (xf_n < 64) begin
          xf_we[xf_n]   <= mem_we;
          xf_addr[xf_n] <= mem_addr;
          xf_data[xf_n] <= mem_we ? mem_wdata : mem[mem_addr];
          xf_n          <= xf_n + 1;
        end
      end
    end
  end

  int both_cnt = 0;
  always @(negedge clock) if (cache_rden && cache_wren) both_cnt <= both_cnt + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one request and returns cycles from the accept edge to cpu_done (-1 on timeout).
  task automatic do_req(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    int guard = 0;
    while (cpu_busy && guard < 100) begin tick(); guard++; end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    lat = 1;
    while (!cpu_done && lat < 100) begin tick(); lat++; end
    if (!cpu_done) lat = -1;
    rd = cpu_rdata;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    checks++;
    if ({cpu_busy, cpu_done, cpu_rdata} !== 34'd0) begin
      failures++; $display("FAIL reset_cpu got=%h exp=0", {cpu_busy, cpu_done, cpu_rdata});
    end
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 38'd0) begin
      failures++; $display("FAIL reset_mem got=%h exp=0", {mem_req, mem_we, mem_addr, mem_wdata});
    end
    i_rst = 1'b0;
    tick();
    checks++;
    if ({cache_rden, cache_wren, cache_address, cache_data} !== 40'd0) begin
      failures++; $display("FAIL reset_cache got=%h exp=0", {cache_rden, cache_wren, cache_address, cache_data});
    end
  endtask

  task automatic test_read_miss();
    int lat, n0; logic [31:0] rd;
    n0 = xf_n;
    do_req(1'b0, 4'h5, 32'h0, lat, rd);
    checks++;
    if (lat !== 7) begin failures++; $display("FAIL read_miss_lat got=%0d exp=7", lat); end
    checks++;
    if (rd !== 32'hA5A5_0005) begin failures++; $display("FAIL read_miss_data got=%h exp=a5a50005", rd); end
    checks++;
    if ((xf_n !== n0 + 1) || (xf_we[n0] !== 1'b0) || (xf_addr[n0] !== 4'h5)) begin
      failures++; $display("FAIL read_miss_fill got_n=%0d we=%b addr=%h exp_n=%0d we=0 addr=5",
                           xf_n - n0, xf_we[n0], xf_addr[n0], 1);
    end
  endtask

  task automatic test_read_hit();
    int lat, n0; logic [31:0] rd;
    n0 = xf_n;
    do_req(1'b0, 4'h5, 32'h0, lat, rd);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL read_hit_lat got=%0d exp=2", lat); end
    checks++;
    if (rd !== 32'hA5A5_0005) begin failures++; $display("FAIL read_hit_data got=%h exp=a5a50005", rd); end
    checks++;
    if (xf_n !== n0) begin failures++; $display("FAIL read_hit_nomem got=%0d exp=0", xf_n - n0); end
  endtask

  task automatic test_write_hit();
    int lat, n0; logic [31:0] rd;
    n0 = xf_n;
    do_req(1'b1, 4'h5, 32'h1234_5678, lat, rd);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL write_hit_lat got=%0d exp=2", lat); end
    checks++;
    if ((xf_n !== n0) || (arr[1] !== {2'b11, 2'b01, 32'h1234_5678})) begin
      failures++; $display("FAIL write_hit_line got=%h xf=%0d exp=d12345678 xf=0", arr[1], xf_n - n0);
    end
  endtask

  task automatic test_dirty_miss();
    int lat, n0; logic [31:0] rd;
    n0 = xf_n;
    do_req(1'b0, 4'h9, 32'h0, lat, rd);
    checks++;
    if (lat !== 11) begin failures++; $display("FAIL dirty_miss_lat got=%0d exp=11", lat); end
    checks++;
    if (rd !== 32'hA5A5_0009) begin failures++; $display("FAIL dirty_miss_data got=%h exp=a5a50009", rd); end
    checks++;
    if ((xf_n !== n0 + 2) || (xf_we[n0] !== 1'b1) || (xf_addr[n0] !== 4'h5) ||
        (xf_data[n0] !== 32'h1234_5678)) begin
      failures++; $display("FAIL dirty_miss_wb got_n=%0d we=%b addr=%h data=%h exp_n=2 we=1 addr=5 data=12345678",
                           xf_n - n0, xf_we[n0], xf_addr[n0], xf_data[n0]);
    end
    checks++;
    if ((xf_we[n0+1] !== 1'b0) || (xf_addr[n0+1] !== 4'h9)) begin
      failures++; $display("FAIL dirty_miss_fill got we=%b addr=%h exp we=0 addr=9", xf_we[n0+1], xf_addr[n0+1]);
    end
    n0 = xf_n;
    do_req(1'b0, 4'h5, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h1234_5678) begin failures++; $display("FAIL refetch_data got=%h exp=12345678", rd); end
    checks++;
    if ((xf_n !== n0 + 1) || (xf_we[n0] !== 1'b0) || (xf_addr[n0] !== 4'h5)) begin
      failures++; $display("FAIL refetch_fill got_n=%0d we=%b addr=%h exp_n=1 we=0 addr=5",
                           xf_n - n0, xf_we[n0], xf_addr[n0]);
    end
  endtask

  task automatic test_stats();
`ifdef CACHE_CTRL_STATS_EN
    checks++;
    if ({hit_cnt, miss_cnt, wb_cnt} !== {16'd2, 16'd3, 16'd1}) begin
      failures++; $display("FAIL stats got hit=%0d miss=%0d wb=%0d exp hit=2 miss=3 wb=1", hit_cnt, miss_cnt, wb_cnt);
    end
`endif
  endtask

  task automatic test_ack_first_cycle();
    int lat, n0; logic [31:0] rd;
    ack_delay = 0;
    n0 = xf_n;
    do_req(1'b1, 4'h6, 32'h0BAD_F00D, lat, rd);
    checks++;
    if ((lat !== 4) || (xf_n !== n0 + 1) || (xf_addr[n0] !== 4'h6)) begin
      failures++; $display("FAIL ack0_write got lat=%0d xf=%0d addr=%h exp lat=4 xf=1 addr=6", lat, xf_n - n0, xf_addr[n0]);
    end
    n0 = xf_n;
    do_req(1'b0, 4'h2, 32'h0, lat, rd);
    checks++;
    if ((lat !== 5) || (rd !== 32'hA5A5_0002)) begin
      failures++; $display("FAIL ack0_read got lat=%0d data=%h exp lat=5 data=a5a50002", lat, rd);
    end
    checks++;
    if ((xf_n !== n0 + 2) || (xf_addr[n0] !== 4'h6) || (xf_data[n0] !== 32'h0BAD_F00D) ||
        (xf_addr[n0+1] !== 4'h2) || (xf_we[n0+1] !== 1'b0)) begin
      failures++; $display("FAIL ack0_xfers got_n=%0d wb_addr=%h wb_data=%h fill_addr=%h exp_n=2 6 0badf00d 2",
                           xf_n - n0, xf_addr[n0], xf_data[n0], xf_addr[n0+1]);
    end
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL ack0_req_idle got=%b exp=0", mem_req); end
    ack_delay = 3;
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h5;
    tick();
    cpu_addr = 4'h2;
    checks++;
    if ({cpu_busy, cpu_done} !== 2'b10) begin
      failures++; $display("FAIL b2b_busy got=%b exp=10", {cpu_busy, cpu_done});
    end
    tick();
    checks++;
    if ({cpu_busy, cpu_done, cpu_rdata} !== {2'b01, 32'h1234_5678}) begin
      failures++; $display("FAIL b2b_first got=%h exp=%h", {cpu_busy, cpu_done, cpu_rdata}, {2'b01, 32'h1234_5678});
    end
    tick();
    cpu_req = 1'b0; cpu_addr = '0;
    checks++;
    if ({cpu_busy, cpu_done} !== 2'b10) begin
      failures++; $display("FAIL b2b_accept got=%b exp=10", {cpu_busy, cpu_done});
    end
    tick();
    checks++;
    if ({cpu_done, cpu_rdata} !== {1'b1, 32'hA5A5_0002}) begin
      failures++; $display("FAIL b2b_second got=%h exp=%h", {cpu_done, cpu_rdata}, {1'b1, 32'hA5A5_0002});
    end
  endtask

  task automatic test_reset_in_writeback();
    int lat, n0, guard; logic [31:0] rd;
    do_req(1'b1, 4'h5, 32'hDEAD_BEEF, lat, rd);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h9;
    tick();
    cpu_req = 1'b0; cpu_addr = '0;
    guard = 0;
    while (!(mem_req && mem_we) && guard < 20) begin tick(); guard++; end
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 4'h5, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL rst_wb_enter got=%h exp=%h", {mem_req, mem_we, mem_addr, mem_wdata},
                           {2'b11, 4'h5, 32'hDEAD_BEEF});
    end
    i_rst = 1'b1;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_busy, cpu_done, cpu_rdata, cache_rden, cache_wren} !== 74'd0) begin
      failures++; $display("FAIL rst_wb_outputs got req=%b busy=%b done=%b rdata=%h rden=%b exp all 0",
                           mem_req, cpu_busy, cpu_done, cpu_rdata, cache_rden);
    end
    i_rst = 1'b0;
    tick();
    n0 = xf_n;
    do_req(1'b0, 4'h5, 32'h0, lat, rd);
    checks++;
    if ((lat !== 7) || (rd !== 32'hA5A5_0005) || (xf_n !== n0 + 1) || (xf_we[n0] !== 1'b0)) begin
      failures++; $display("FAIL rst_wb_after got lat=%0d data=%h xf=%0d exp lat=7 data=a5a50005 xf=1",
                           lat, rd, xf_n - n0);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_stats();
    test_ack_first_cycle();
    test_back_to_back();
    test_reset_in_writeback();
    checks++;
    if (both_cnt !== 0) begin failures++; $display("FAIL rden_wren_overlap got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
